piso_ctrl: RTL

PISO_CTRL -- requirements
Module: piso_ctrl

---
 rtl/piso_pkg.sv | 17 +
 rtl/piso_shreg.sv | 40 ++++
 rtl/piso_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared constants and types for the parallel-in/serial-out controller.
package piso_pkg;

  localparam int W_DEFAULT     = 4;
  localparam int CNT_W_DEFAULT = $clog2(W_DEFAULT);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// W-bit shift register with clear, parallel load and MSB-first shift.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         load,
  input  logic         shift_en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_d;
  logic [W-1:0] sr_q;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (load) begin
      sr_d = d;
    end else if (shift_en) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/piso_ctrl.sv
// Serializer control: IDLE/SHIFT FSM, bit counter and output decode around piso_shreg.
module piso_ctrl
  import piso_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         pause,
  output logic         so,
  output logic         so_valid,
  output logic         sof,
  output logic         eof,
  output logic         busy
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [W-1:0]  sr;
  logic          load;
  logic          shift_en;
  logic          clr;
  logic          active;
  logic          last;
  logic          xfer;

  assign active = (state_q == SHIFT) && !pause;
  assign last   = (cnt_q == CNT_LAST);

  // Ready on the last bit lets the next word load with no bubble; gated by
  // reset so upstream never sees a handshake while the block is held.
  assign din_ready = RSTn && ((state_q == IDLE) || (active && last));
  assign xfer      = din_valid && din_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift_en = 1'b0;
    clr      = 1'b0;
    if (xfer) begin
      state_d = SHIFT;
      cnt_d   = '0;
      load    = 1'b1;
    end else if (active) begin
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
        clr     = 1'b1;
      end else begin
        cnt_d    = cnt_q + 1'b1;
        shift_en = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shreg #(.W(W)) u_shreg (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .load     (load),
    .shift_en (shift_en),
    .clr      (clr),
    .d        (din),
    .q        (sr)
  );

  assign so       = sr[W-1];
  assign so_valid = active;
  assign sof      = active && (cnt_q == '0);
  assign eof      = active && last;
  assign busy     = (state_q == SHIFT);

endmodule
